al_vio_commit_ctrl: RTL and testbench
=====================================

AL_VIO_COMMIT_CTRL -- requirements
Module: al_vio_commit_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 4, meaning commit lanes read per cycle.
REQ-002 The block SHALL have parameter DEPTH, default 128, meaning active-list entries (power of two).
REQ-003 The block SHALL have parameter INDEX, default 7, meaning log2(DEPTH).
REQ-004 The block SHALL have parameter WIDTH, default 2, meaning violation bits per entry: bit0 load violation, bit1 exception.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning reset; it SHALL be asynchronous and active-high.
REQ-007 The block SHALL have port alHead_i, input, INDEX, meaning active-list head index.
REQ-008 The block SHALL have port alCount_i, input, INDEX+1, meaning occupied entries, 0..DEPTH.
REQ-009 The block SHALL have port ctrlReady_i, input, CW, meaning bit k is set when entry head+k has completed execution.
REQ-010 The block SHALL have port stall_i, input, 1, meaning commit is blocked this cycle.
REQ-011 The block SHALL have port vioAddr_o, output, CW x INDEX, meaning combinational read address per lane into the violation RAM.
REQ-012 The block SHALL have port vioData_i, input, CW x WIDTH, meaning same-cycle read data per lane.
REQ-013 The block SHALL have port commitValid_o, output, CW, meaning registered lane-commit mask.
REQ-014 The block SHALL have port commitCnt_o, output, log2(CW)+1, meaning registered popcount of commitValid_o.
REQ-015 The block SHALL have port recoverFlush_o, output, 1, meaning registered one-cycle flush pulse.
REQ-016 The block SHALL have port recoverAlIdx_o, output, INDEX, meaning active-list index of the violating entry.
REQ-017 The block SHALL have port recoverCause_o, output, WIDTH, meaning the violating entry's violation bits.
REQ-018 The block SHALL have port recoveryDone_i, input, 1, meaning the pipeline flush has completed.
REQ-019 The block SHALL have port busy_o, output, 1, meaning the FSM is not in IDLE.
REQ-020 The block SHALL have port timeout_o, output, 1, meaning a sticky flag for a recovery watchdog expiry.

Function
REQ-021 The block SHALL drive vioAddr_o[k] as (alHead_i + k) truncated to INDEX bits, so that addresses wrap modulo DEPTH.
REQ-022 The block SHALL treat lane k as eligible when all of: k < alCount_i, ctrlReady_i[k] set, and every lane j < k is eligible with vioData_i[j] equal to 0.
REQ-023 The block SHALL designate the first eligible lane with nonzero vioData_i as the violator; lanes before it SHALL commit and the violator SHALL NOT commit.
REQ-024 The FSM SHALL have three states: IDLE, FLUSH and WAIT.
REQ-025 In IDLE with stall_i low, the block SHALL register commitValid_o/commitCnt_o from eligible non-violating lanes.
REQ-026 In IDLE with stall_i low and a violator present, the block SHALL also latch recoverAlIdx_o (its address) and recoverCause_o, and move to FLUSH.
REQ-027 In IDLE with stall_i high, the block SHALL register commitValid_o=0 and commitCnt_o=0, SHALL NOT perform violation detection, and SHALL stay in IDLE.
REQ-028 In FLUSH, the block SHALL hold recoverFlush_o high for exactly one cycle, force commitValid_o=0, and move to WAIT.
REQ-029 In WAIT, the block SHALL hold commitValid_o at 0 and increment an 8-bit saturating counter each cycle; on recoveryDone_i it SHALL return to IDLE and clear the counter.
REQ-030 recoveryDone_i SHALL be sampled only in WAIT; in IDLE or FLUSH it SHALL be ignored.
REQ-031 When the WAIT counter reaches 255, the block SHALL set timeout_o and keep it set until reset.
REQ-032 With alCount_i = 0, the block SHALL commit nothing and detect no violation.
REQ-033 recoverAlIdx_o and recoverCause_o SHALL hold their values until the next violation is latched.

Reset
REQ-034 On reset the block SHALL put the FSM in IDLE and clear commitValid_o, commitCnt_o, recoverFlush_o, recoverAlIdx_o, recoverCause_o, timeout_o and the counter to 0, with busy_o=0.
REQ-035 Reset asserted during FLUSH or WAIT SHALL abort recovery immediately, with no flush pulse after deassertion.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, violation cause bit positions and the 255-cycle watchdog limit constant.
REQ-037 The combinational lane eligibility/violator priority scan SHALL be one sub-module, al_vio_lane_scan.

Verification
REQ-038 head=5, count=10, ready=1111, vio all 0 -> next cycle commitValid=1111, commitCnt=4, addrs 5,6,7,8.
REQ-039 head=126, count=4, ready=1111, vio lane2=01 -> commitValid=0011, cnt=2; addrs 126,127,0,1; next cycle flush=1, recoverAlIdx=0, cause=01; then WAIT.
REQ-040 ready=1011, vio 0 -> commitValid=0011, cnt=2; count=1 with ready=1111 -> commitValid=0001.
REQ-041 violation with stall_i=1 -> no commit, no flush; stall_i dropped -> flush follows.
REQ-042 In WAIT, recoveryDone held low 260 cycles -> timeout_o=1 at cycle 255 and stays; recoveryDone -> IDLE, timeout_o still 1.
REQ-043 reset asserted one cycle after flush pulse -> all outputs 0, IDLE, no further flush.

Source files
------------

// File: rtl/al_vio_commit_ctrl_pkg.sv
// Shared definitions for the violation-aware commit controller:
// the recovery FSM states, the violation cause bit positions and the watchdog limit.
package al_vio_commit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int CAUSE_LDVIO_BIT = 0;
    localparam int CAUSE_EXC_BIT   = 1;

    localparam logic [7:0] WDOG_LIMIT = 8'd255;

endpackage

// File: rtl/al_vio_lane_scan.sv
// Combinational priority scan over the commit window: per-lane RAM addresses,
// the in-order commit mask and the first violating entry.
module al_vio_lane_scan #(
    parameter int CW    = 4,
    parameter int INDEX = 7,
    parameter int WIDTH = 2
) (
    input  logic [INDEX-1:0]            i_head,
    input  logic [INDEX:0]              i_count,
    input  logic [CW-1:0]               i_ready,
    input  logic [CW-1:0][WIDTH-1:0]    i_vioData,
    output logic [CW-1:0][INDEX-1:0]    o_addr,
    output logic [CW-1:0]               o_commit,
    output logic                        o_vioValid,
    output logic [INDEX-1:0]            o_vioIdx,
    output logic [WIDTH-1:0]            o_vioCause
);

    logic w_chain;
    logic w_elig;

    always_comb begin
        o_addr     = '0;
        o_commit   = '0;
        o_vioValid = 1'b0;
        o_vioIdx   = '0;
        o_vioCause = '0;
        w_chain    = 1'b1;
        w_elig     = 1'b0;
        for (int k = 0; k < CW; k++) begin
            // Address arithmetic is INDEX bits wide, so the window wraps modulo DEPTH.
            o_addr[k] = i_head + INDEX'(k);
            w_elig    = w_chain && ((INDEX+1)'(k) < i_count) && i_ready[k];
            if (w_elig && (i_vioData[k] != '0) && !o_vioValid) begin
                o_vioValid = 1'b1;
                o_vioIdx   = o_addr[k];
                o_vioCause = i_vioData[k];
            end
            o_commit[k] = w_elig && (i_vioData[k] == '0);
            w_chain     = o_commit[k];
        end
    end

endmodule

// File: rtl/al_vio_commit_ctrl.sv
// Commit controller: retires ready, violation-free entries in order and runs a
// flush/wait recovery sequence with a sticky watchdog when a violator reaches commit.
module al_vio_commit_ctrl #(
    parameter int CW    = 4,
    parameter int DEPTH = 128,
    parameter int INDEX = 7,
    parameter int WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INDEX-1:0]              alHead_i,
    input  logic [INDEX:0]                alCount_i,
    input  logic [CW-1:0]                 ctrlReady_i,
    input  logic                          stall_i,
    output logic [CW-1:0][INDEX-1:0]      vioAddr_o,
    input  logic [CW-1:0][WIDTH-1:0]      vioData_i,
    output logic [CW-1:0]                 commitValid_o,
    output logic [$clog2(CW):0]           commitCnt_o,
    output logic                          recoverFlush_o,
    output logic [INDEX-1:0]              recoverAlIdx_o,
    output logic [WIDTH-1:0]              recoverCause_o,
    input  logic                          recoveryDone_i,
    output logic                          busy_o,
    output logic                          timeout_o
);

    import al_vio_commit_ctrl_pkg::*;

    localparam int CNTW = $clog2(CW) + 1;

    function automatic logic [CNTW-1:0] popcnt(input logic [CW-1:0] v);
        logic [CNTW-1:0] s;
        s = '0;
        for (int k = 0; k < CW; k++) begin
            s = s + CNTW'(v[k]);
        end
        return s;
    endfunction

    state_t              r_state;
    logic [CW-1:0]       r_commitValid;
    logic [CNTW-1:0]     r_commitCnt;
    logic                r_flush;
    logic [INDEX-1:0]    r_alIdx;
    logic [WIDTH-1:0]    r_cause;
    logic [7:0]          r_wdCnt;
    logic                r_timeout;

    logic [INDEX:0]      w_count;
    logic [CW-1:0]       w_commit;
    logic                w_vioValid;
    logic [INDEX-1:0]    w_vioIdx;
    logic [WIDTH-1:0]    w_vioCause;

    // An out-of-range occupancy never opens lanes beyond the list size.
    assign w_count = (alCount_i > (INDEX+1)'(DEPTH)) ? (INDEX+1)'(DEPTH) : alCount_i;

    al_vio_lane_scan #(
        .CW    (CW),
        .INDEX (INDEX),
        .WIDTH (WIDTH)
    ) u_scan (
        .i_head     (alHead_i),
        .i_count    (w_count),
        .i_ready    (ctrlReady_i),
        .i_vioData  (vioData_i),
        .o_addr     (vioAddr_o),
        .o_commit   (w_commit),
        .o_vioValid (w_vioValid),
        .o_vioIdx   (w_vioIdx),
        .o_vioCause (w_vioCause)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_commitValid <= '0;
            r_commitCnt   <= '0;
            r_flush       <= 1'b0;
            r_alIdx       <= '0;
            r_cause       <= '0;
            r_wdCnt       <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_commitValid <= '0;
            r_commitCnt   <= '0;
            r_flush       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!stall_i) begin
                        r_commitValid <= w_commit;
                        r_commitCnt   <= popcnt(w_commit);
                        if (w_vioValid) begin
                            r_alIdx <= w_vioIdx;
                            r_cause <= w_vioCause;
                            r_flush <= 1'b1;
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (recoveryDone_i) begin
                        r_wdCnt <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_wdCnt != WDOG_LIMIT) begin
                            r_wdCnt <= r_wdCnt + 8'd1;
                        end
                        if (r_wdCnt >= WDOG_LIMIT - 8'd1) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign commitValid_o  = r_commitValid;
    assign commitCnt_o    = r_commitCnt;
    assign recoverFlush_o = r_flush;
    assign recoverAlIdx_o = r_alIdx;
    assign recoverCause_o = r_cause;
    assign busy_o         = (r_state != ST_IDLE);
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_al_vio_commit_ctrl.sv
// Directed bench for al_vio_commit_ctrl: expected register snapshots are queued
// as each step is driven and compared after the following clock edge.
module tb_al_vio_commit_ctrl;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       alHead;
    logic [7:0]       alCount;
    logic [3:0]       ctrlReady;
    logic             stall;
    logic [3:0][6:0]  vioAddr;
    logic [3:0][1:0]  vioData;
    logic [3:0]       commitValid;
    logic [2:0]       commitCnt;
    logic             recoverFlush;
    logic [6:0]       recoverAlIdx;
    logic [1:0]       recoverCause;
    logic             recoveryDone;
    logic             busy;
    logic             timeout;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [3:0] cv;
        logic [2:0] cnt;
        logic       fl;
        logic [6:0] idx;
        logic [1:0] cause;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];

    al_vio_commit_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .alHead_i       (alHead),
        .alCount_i      (alCount),
        .ctrlReady_i    (ctrlReady),
        .stall_i        (stall),
        .vioAddr_o      (vioAddr),
        .vioData_i      (vioData),
        .commitValid_o  (commitValid),
        .commitCnt_o    (commitCnt),
        .recoverFlush_o (recoverFlush),
        .recoverAlIdx_o (recoverAlIdx),
        .recoverCause_o (recoverCause),
        .recoveryDone_i (recoveryDone),
        .busy_o         (busy),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] cv, input logic [2:0] cnt, input logic fl,
                        input logic [6:0] idx, input logic [1:0] cause,
                        input logic bsy, input logic to);
        exp_t e;
        e.cv = cv; e.cnt = cnt; e.fl = fl; e.idx = idx;
        e.cause = cause; e.busy = bsy; e.to = to;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".commitValid"}, 32'(commitValid),  32'(e.cv));
        chk({tag, ".commitCnt"},   32'(commitCnt),    32'(e.cnt));
        chk({tag, ".flush"},       32'(recoverFlush), 32'(e.fl));
        chk({tag, ".alIdx"},       32'(recoverAlIdx), 32'(e.idx));
        chk({tag, ".cause"},       32'(recoverCause), 32'(e.cause));
        chk({tag, ".busy"},        32'(busy),         32'(e.busy));
        chk({tag, ".timeout"},     32'(timeout),      32'(e.to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        alHead = '0; alCount = '0; ctrlReady = '0; stall = 1'b0;
        vioData = '0; recoveryDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(4'h0, 3'd0, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        check_pop("reset");
        reset = 1'b0;

        // full window commit
        alHead = 7'd5; alCount = 8'd10; ctrlReady = 4'b1111; vioData = '0;
        #1;
        chk("addr_h5_0", 32'(vioAddr[0]), 32'd5);
        chk("addr_h5_1", 32'(vioAddr[1]), 32'd6);
        chk("addr_h5_2", 32'(vioAddr[2]), 32'd7);
        chk("addr_h5_3", 32'(vioAddr[3]), 32'd8);
        push(4'b1111, 3'd4, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("full");

        // lane 2 not ready stops the in-order scan
        ctrlReady = 4'b1011;
        push(4'b0011, 3'd2, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("ready_gap");

        alCount = 8'd1; ctrlReady = 4'b1111;
        push(4'b0001, 3'd1, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("count1");

        // empty list: no commit and no violation even with vio data present
        alCount = 8'd0; vioData[0] = 2'b01;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("count0");

        // violation under stall, with head near the wrap point
        alHead = 7'd126; alCount = 8'd4; ctrlReady = 4'b1111;
        vioData = '0; vioData[2] = 2'b01; stall = 1'b1;
        #1;
        chk("addr_wrap_0", 32'(vioAddr[0]), 32'd126);
        chk("addr_wrap_1", 32'(vioAddr[1]), 32'd127);
        chk("addr_wrap_2", 32'(vioAddr[2]), 32'd0);
        chk("addr_wrap_3", 32'(vioAddr[3]), 32'd1);
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("stall_vio");

        stall = 1'b0;
        push(4'b0011, 3'd2, 1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        tick(); check_pop("vio_detect");

        // recoveryDone during FLUSH is ignored
        vioData = '0; recoveryDone = 1'b1;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b01, 1'b1, 1'b0);
        tick(); check_pop("flush_to_wait");

        recoveryDone = 1'b0;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b01, 1'b1, 1'b0);
        tick(); check_pop("wait1");

        // a new violator in WAIT must not be latched
        alHead = 7'd40; vioData[0] = 2'b10;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b01, 1'b1, 1'b0);
        tick(); check_pop("wait2");

        // watchdog: counter value n after the n-th WAIT edge, flag once it reaches 255
        for (int n = 3; n <= 260; n++) begin
            push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b01, 1'b1, (n >= 255) ? 1'b1 : 1'b0);
            tick();
            check_pop($sformatf("wdog%0d", n));
        end

        recoveryDone = 1'b1; vioData = '0;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b01, 1'b0, 1'b1);
        tick(); check_pop("done_idle");
        recoveryDone = 1'b0;

        // second violation: lane 0 commits, lane 1 violates with both cause bits
        alHead = 7'd20; alCount = 8'd3; ctrlReady = 4'b1111;
        vioData = '0; vioData[1] = 2'b11;
        push(4'b0001, 3'd1, 1'b1, 7'd21, 2'b11, 1'b1, 1'b1);
        tick(); check_pop("vio2");

        vioData = '0;
        push(4'b0000, 3'd0, 1'b0, 7'd21, 2'b11, 1'b1, 1'b1);
        tick(); check_pop("vio2_wait");

        // asynchronous reset in WAIT aborts recovery
        reset = 1'b1;
        #1;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        check_pop("async_reset");
        alCount = 8'd0;
        tick();
        reset = 1'b0;
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("post_reset1");
        push(4'b0000, 3'd0, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        tick(); check_pop("post_reset2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
